// File: rtl/axi_slv_burst_ctrl.sv
// AXI3 slave burst controller: arbitrates AW/AR, sequences AW->W->B and AR->R bursts,
// and generates per-beat addresses for FIXED/INCR/WRAP into a single-port word memory.
module axi_slv_burst_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_W = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [3:0]            awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [3:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [3:0]            wid,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [3:0]            bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [3:0]            arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [3:0]            rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_W-1:0]     mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [2:0]            dbg_state
);

    localparam int MAX_SIZE = $clog2(STRB_W);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_DATA = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;

    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;

    logic [2:0]            r_state;
    logic [3:0]            r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [4:0]            r_beat_cnt;
    logic                  r_err;
    logic                  r_last_grant;

    logic                  w_idle;
    logic                  w_aw_win;
    logic                  w_aw_hs;
    logic                  w_ar_hs;
    logic                  w_wr_hs;
    logic                  w_in_range;
    logic                  w_beat_last;
    logic                  w_wr_mem;
    logic [3:0]            w_sel_id;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [3:0]            w_sel_len;
    logic [2:0]            w_sel_size;
    logic [1:0]            w_sel_burst;

    function automatic logic decode_err(input logic [3:0] len, input logic [2:0] size,
                                        input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = (burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
        return (int'(size) > MAX_SIZE) || (burst == 2'b11) || bad_wrap;
    endfunction

    // WRAP stays inside a container of (len+1) beats aligned to its own size.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [3:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        incr = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) + ((addr + incr) & mask);
            default: next_addr = (addr & ~(incr - ADDR_WIDTH'(1))) + incr;
        endcase
    endfunction

    assign w_idle   = (r_state == S_IDLE) && aresetn;
    assign w_aw_win = awvalid && (!arvalid || (r_last_grant == GRANT_READ));
    assign awready  = w_idle && w_aw_win;
    assign arready  = w_idle && arvalid && !w_aw_win;
    assign w_aw_hs  = awvalid && awready;
    assign w_ar_hs  = arvalid && arready;

    assign w_sel_id    = w_aw_hs ? awid    : arid;
    assign w_sel_addr  = w_aw_hs ? awaddr  : araddr;
    assign w_sel_len   = w_aw_hs ? awlen   : arlen;
    assign w_sel_size  = w_aw_hs ? awsize  : arsize;
    assign w_sel_burst = w_aw_hs ? awburst : arburst;

    assign wready      = (r_state == S_WR_DATA) && aresetn;
    assign w_wr_hs     = wready && wvalid;
    assign w_in_range  = r_beat_cnt <= {1'b0, r_len};
    assign w_beat_last = r_beat_cnt == {1'b0, r_len};
    assign w_wr_mem    = w_wr_hs && !r_err && w_in_range;

    assign mem_en    = w_wr_mem || ((r_state == S_RD_REQ) && aresetn && !r_err);
    assign mem_we    = w_wr_mem;
    assign mem_addr  = r_addr;
    assign mem_wdata = w_wr_hs ? wdata : '0;
    assign mem_wstrb = w_wr_hs ? wstrb : '0;

    assign bvalid = (r_state == S_WR_RESP);
    assign bid    = bvalid ? r_id : 4'd0;
    assign bresp  = (bvalid && r_err) ? 2'b10 : 2'b00;

    assign rvalid = (r_state == S_RD_DATA);
    assign rid    = rvalid ? r_id : 4'd0;
    assign rdata  = (rvalid && !r_err) ? mem_rdata : '0;
    assign rresp  = (rvalid && r_err) ? 2'b10 : 2'b00;
    assign rlast  = rvalid && w_beat_last;

    assign dbg_state = r_state;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_beat_cnt   <= '0;
            r_err        <= 1'b0;
            r_last_grant <= GRANT_READ;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs || w_ar_hs) begin
                        r_id       <= w_sel_id;
                        r_addr     <= w_sel_addr;
                        r_len      <= w_sel_len;
                        r_size     <= w_sel_size;
                        r_burst    <= w_sel_burst;
                        r_beat_cnt <= '0;
                        r_err      <= decode_err(w_sel_len, w_sel_size, w_sel_burst);
                        r_state    <= w_aw_hs ? S_WR_DATA : S_RD_REQ;
                    end
                end
                S_WR_DATA: begin
                    if (wvalid) begin
                        if ((wid != r_id) || (wlast && !w_beat_last) || !w_in_range)
                            r_err <= 1'b1;
                        if (wlast) begin
                            r_state <= S_WR_RESP;
                        end else begin
                            // Saturate so a runaway W stream keeps reporting out-of-range.
                            if (r_beat_cnt != 5'h1F)
                                r_beat_cnt <= r_beat_cnt + 5'd1;
                            r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
                        end
                    end
                end
                S_WR_RESP: begin
                    if (bready) begin
                        r_state      <= S_IDLE;
                        r_last_grant <= GRANT_WRITE;
                    end
                end
                S_RD_REQ: r_state <= S_RD_DATA;
                S_RD_DATA: begin
                    if (rready) begin
                        if (w_beat_last) begin
                            r_state      <= S_IDLE;
                            r_last_grant <= GRANT_READ;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 5'd1;
                            r_addr     <= next_addr(r_addr, r_len, r_size, r_burst);
                            r_state    <= S_RD_REQ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slv_burst_ctrl.sv
// Directed bench for axi_slv_burst_ctrl: word memory model, fixed-latency directed steps,
// immediate assertions at every comparison point.
module tb_axi_slv_burst_ctrl;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_mem_acc = 0;
    int acc_before;

    logic [31:0] mem [0:1023];
    bit          written [0:1023];

    axi_slv_burst_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Clock
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Word memory: unwritten words read back as 0xA5000000 | word index.
    always @(posedge aclk) begin
        if (mem_en) begin
            n_mem_acc++;
            if (mem_we) begin
                written[mem_addr[11:2]] <= 1'b1;
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b])
                        mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= written[mem_addr[11:2]] ? mem[mem_addr[11:2]]
                                                      : (32'hA500_0000 | 32'(mem_addr[11:2]));
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic aw_xfer(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        #1;
        chk("aw_ready", awready, 1);
        chk("aw_ar_blocked", arready, 0);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic ar_xfer(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        #1;
        chk("ar_ready", arready, 1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic wr_beat(input logic [3:0] id, input logic [31:0] data, input logic last,
                           input logic exp_en, input logic [31:0] exp_addr);
        wid = id; wdata = data; wstrb = 4'hF; wlast = last; wvalid = 1'b1;
        #1;
        chk("w_ready", wready, 1);
        chk("w_mem_en", mem_en, exp_en);
        if (exp_en) begin
            chk("w_mem_we", mem_we, 1);
            chk("w_mem_addr", mem_addr, exp_addr);
            chk("w_mem_wdata", mem_wdata, data);
        end
        tick();
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic b_resp(input logic [3:0] id, input logic [1:0] resp);
        bready = 1'b1;
        #1;
        chk("b_valid", bvalid, 1);
        chk("b_id", bid, id);
        chk("b_resp", bresp, resp);
        tick();
        chk("b_valid_drop", bvalid, 0);
    endtask

    task automatic rd_beat(input logic exp_en, input logic [31:0] exp_addr, input logic [31:0] exp_data,
                           input logic exp_last, input logic [3:0] id, input logic [1:0] resp,
                           input bit hold);
        rready = 1'b0;
        #1;
        chk("rd_req_mem_en", mem_en, exp_en);
        if (exp_en) begin
            chk("rd_req_mem_we", mem_we, 0);
            chk("rd_req_addr", mem_addr, exp_addr);
        end
        tick();
        if (hold) begin
            #1;
            chk("rd_hold_rvalid", rvalid, 1);
            chk("rd_hold_rdata", rdata, exp_data);
            tick();
            chk("rd_hold2_rvalid", rvalid, 1);
            chk("rd_hold2_rdata", rdata, exp_data);
            chk("rd_hold2_rlast", rlast, exp_last);
        end
        rready = 1'b1;
        #1;
        chk("r_valid", rvalid, 1);
        chk("r_id", rid, id);
        chk("r_data", rdata, exp_data);
        chk("r_resp", rresp, resp);
        chk("r_last", rlast, exp_last);
        tick();
        rready = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
        repeat (3) tick();

        // Reset values
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_state", dbg_state, 0);
        aresetn = 1'b1;
        tick();

        // Simultaneous AW/AR after reset: write wins, then read wins
        awid = 4'h3; awaddr = 32'h200; awlen = 0; awsize = 2; awburst = 2'b01; awvalid = 1'b1;
        arid = 4'h5; araddr = 32'h40;  arlen = 0; arsize = 2; arburst = 2'b01; arvalid = 1'b1;
        #1;
        chk("arb1_awready", awready, 1);
        chk("arb1_arready", arready, 0);
        tick();
        awvalid = 1'b0;
        wr_beat(4'h3, 32'hCAFE_0001, 1'b1, 1'b1, 32'h200);
        b_resp(4'h3, 2'b00);
        awvalid = 1'b1;
        #1;
        chk("arb2_arready", arready, 1);
        chk("arb2_awready", awready, 0);
        tick();
        awvalid = 1'b0;
        rd_beat(1'b1, 32'h40, 32'hA500_0010, 1'b1, 4'h5, 2'b00, 1'b0);
        chk("arb_mem_200", mem[32'h200 >> 2], 32'hCAFE_0001);

        // INCR write, 4 beats from 0x100
        aw_xfer(4'hA, 32'h100, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++)
            wr_beat(4'hA, 32'h1111_0000 + 32'(i), i == 3, 1'b1, 32'h100 + 32'(4 * i));
        b_resp(4'hA, 2'b00);
        for (int i = 0; i < 4; i++)
            chk("incr_mem", mem[(32'h100 >> 2) + i], 32'h1111_0000 + 32'(i));

        // WRAP read from 0x38, first beat held with rready low
        ar_xfer(4'h6, 32'h38, 4'd3, 3'd2, 2'b10);
        rd_beat(1'b1, 32'h38, 32'hA500_000E, 1'b0, 4'h6, 2'b00, 1'b1);
        rd_beat(1'b1, 32'h3C, 32'hA500_000F, 1'b0, 4'h6, 2'b00, 1'b0);
        rd_beat(1'b1, 32'h30, 32'hA500_000C, 1'b0, 4'h6, 2'b00, 1'b0);
        rd_beat(1'b1, 32'h34, 32'hA500_000D, 1'b1, 4'h6, 2'b00, 1'b0);
        chk("wrap_idle", dbg_state, 0);

        // Early wlast: two writes land, SLVERR
        aw_xfer(4'h2, 32'h300, 4'd3, 3'd2, 2'b01);
        wr_beat(4'h2, 32'h2222_0000, 1'b0, 1'b1, 32'h300);
        wr_beat(4'h2, 32'h2222_0001, 1'b1, 1'b1, 32'h304);
        b_resp(4'h2, 2'b10);

        // Oversized beat: no memory traffic, SLVERR
        acc_before = n_mem_acc;
        aw_xfer(4'h7, 32'h400, 4'd1, 3'd3, 2'b01);
        wr_beat(4'h7, 32'h3333_0000, 1'b0, 1'b0, 32'h0);
        wr_beat(4'h7, 32'h3333_0001, 1'b1, 1'b0, 32'h0);
        b_resp(4'h7, 2'b10);
        chk("size_err_no_mem", n_mem_acc, acc_before);

        // Reserved burst type on read: 2 beats of zero data, SLVERR, no memory traffic
        acc_before = n_mem_acc;
        ar_xfer(4'h9, 32'h50, 4'd1, 3'd2, 2'b11);
        rd_beat(1'b0, 32'h0, 32'h0, 1'b0, 4'h9, 2'b10, 1'b0);
        rd_beat(1'b0, 32'h0, 32'h0, 1'b1, 4'h9, 2'b10, 1'b0);
        chk("burst_err_no_mem", n_mem_acc, acc_before);

        // Reset during beat 2 of a 4-beat write
        aw_xfer(4'h1, 32'h500, 4'd3, 3'd2, 2'b01);
        wr_beat(4'h1, 32'h4444_0000, 1'b0, 1'b1, 32'h500);
        wid = 4'h1; wdata = 32'h4444_0001; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        aresetn = 1'b0;
        tick();
        wvalid = 1'b0;
        #1;
        chk("midrst_state", dbg_state, 0);
        chk("midrst_wready", wready, 0);
        chk("midrst_bvalid", bvalid, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_rvalid", rvalid, 0);
        aresetn = 1'b1;
        tick();
        chk("postrst_bvalid", bvalid, 0);
        chk("postrst_state", dbg_state, 0);
        aw_xfer(4'hC, 32'h600, 4'd0, 3'd2, 2'b01);
        wr_beat(4'hC, 32'h5555_0000, 1'b1, 1'b1, 32'h600);
        b_resp(4'hC, 2'b00);
        chk("postrst_mem_600", mem[32'h600 >> 2], 32'h5555_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
